fetch_queue: RTL and testbench

Parametrised prefetching fetch stage. Holds the program counter, issues sequential instruction-memory reads through a valid/ready request port that tolerates variable latency, and buffers returned instructions in a DEPTH-entry queue. Decode pops the queue through a valid/ready handshake. A redirect (branch, jump or jump-register target resolved downstream) flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the prefetching fetch stage.
//   fetch_state_e : fetch controller states (IDLE, RUN, HALTED)
//   *_DEF         : default parameter values for the fetch stage
//   cnt_w()       : width of a counter that must hold 0..n inclusive
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int ADDR_W_DEF   = 16;
    localparam int INSTR_W_DEF  = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int PC_INC_DEF   = 2;
    localparam int RESET_PC_DEF = 0;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: control, instruction-memory and decode signals of the fetch stage.
//   control : halt, redirect, redirect_pc
//   imem    : imem_req_valid/ready/addr, imem_rsp_valid/data
//   decode  : instr_valid/ready, instr, instr_pc, instr_next_pc
//   status  : busy
// master = fetch stage side, slave = environment (memory, decode, control).
interface fetch_queue_if #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
    parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
);
    logic               halt;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [ADDR_W-1:0]  instr_next_pc;
    logic               busy;

    modport master (
        input  halt, redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               instr_next_pc, busy
    );

    modport slave (
        output halt, redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               instr_next_pc, busy
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, DEPTH a power of two.
//   clk, rst  : clock, asynchronous active-low reset
//   i_flush   : empties the FIFO; overrides push and pop in the same cycle
//   i_push    : write i_data (accepted when not full, or full with a pop)
//   i_pop     : drop the head entry (ignored when empty)
//   o_data    : head entry, zero while empty
//   o_count   : number of stored entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_data,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch stage with a DEPTH-entry instruction queue.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : fetch_queue_if master (control, imem request/response, decode, busy)
// Parameters ADDR_W/INSTR_W must match those of the connected interface.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | one cycle after reset, no requests
// RUN    | issuing sequential reads while credit is available
// HALTED | halt held high, no new requests, responses still land
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PC_INC   = PC_INC_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int ENT_W = INSTR_W + ADDR_W;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [CNT_W-1:0]  w_q_count;
    logic [CNT_W-1:0]  w_side_count;
    logic [CNT_W-1:0]  w_outstanding;
    logic [CNT_W-1:0]  w_rsp_dec;
    logic [ENT_W-1:0]  w_q_head;
    logic [ADDR_W-1:0] w_side_head;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_drop;
    logic              w_push;
    logic              w_q_valid;
    logic              w_pop;

    // Every outstanding request is either still paired with a PC in the
    // side-queue or already condemned by a redirect and counted in drop_cnt.
    assign w_outstanding = w_side_count + r_drop_cnt;
    assign w_rsp_dec     = {{(CNT_W-1){1'b0}}, bus.imem_rsp_valid};

    // Credit reserves a queue slot for every request still in flight.
    assign w_credit    = ({1'b0, w_q_count} + {1'b0, w_outstanding}) < (CNT_W+1)'(DEPTH);
    assign w_req_valid = (r_state == RUN) && !bus.redirect && w_credit;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;

    assign w_drop    = (r_drop_cnt != '0);
    assign w_push    = bus.imem_rsp_valid && !w_drop && !bus.redirect;
    assign w_q_valid = (w_q_count != '0);
    assign w_pop     = w_q_valid && bus.instr_ready && !bus.redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (bus.halt)  r_state <= HALTED;
                HALTED:  if (!bus.halt) r_state <= RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
        end else if (w_req_fire) begin
            r_pc <= r_pc + ADDR_W'(PC_INC);
        end
    end

    // No request can fire during a redirect, so only this cycle's response
    // reduces the number of stale beats still to come.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (bus.redirect) begin
            r_drop_cnt <= w_outstanding - w_rsp_dec;
        end else if (bus.imem_rsp_valid && w_drop) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
    end

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_side_q (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_push),
        .o_data  (w_side_head),
        .o_count (w_side_count)
    );

    fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect),
        .i_push  (w_push),
        .i_data  ({bus.imem_rsp_data, w_side_head}),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_count (w_q_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_q_valid;
    assign bus.instr          = w_q_head[ENT_W-1:ADDR_W];
    assign bus.instr_pc       = w_q_head[ADDR_W-1:0];
    assign bus.instr_next_pc  = w_q_head[ADDR_W-1:0] + ADDR_W'(PC_INC);
    assign bus.busy           = (w_outstanding != '0) || w_q_valid;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pc;
    } ent_t;

    logic clk;
    logic rst;

    fetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    fetch_queue #(
        .ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .PC_INC(2), .RESET_PC(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_req = 0;
    int n_pops = 0;
    logic [15:0] first_addr;
    logic [15:0] first_pop_pc;
    logic [15:0] wrap_next;

    // stimulus knobs
    bit          k_halt, k_redir, k_rdy, k_ir;
    logic [15:0] k_rpc;
    int          k_lat_min, k_lat_max;

    // reference model
    int          m_state;   // 0 idle, 1 run, 2 halted
    int          m_out, m_drop;
    logic [15:0] m_pc;
    ent_t        m_q[$];
    logic [15:0] m_side[$];

    // memory
    logic [15:0] mem_addr[$];
    int          mem_due[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit rsp_due();
        return (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    endfunction

    task automatic step();
        bit          rsp, rv, dfire;
        logic [15:0] daddr;
        ent_t        e;
        bus.halt           = k_halt;
        bus.redirect       = k_redir;
        bus.redirect_pc    = k_rpc;
        bus.instr_ready    = k_ir;
        bus.imem_req_ready = k_rdy;
        rsp = rsp_due();
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (mem_addr[0] ^ 16'hA000) : 16'h0000;
        #1;
        rv = (m_state == 1) && !k_redir && (m_q.size() + m_out < DEPTH);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(rv));
        chk("req_addr", 32'(bus.imem_req_addr), 32'(m_pc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("instr", 32'(bus.instr), 32'(m_q[0].ins));
            chk("instr_pc", 32'(bus.instr_pc), 32'(m_q[0].pc));
            chk("instr_next_pc", 32'(bus.instr_next_pc), 32'(16'(m_q[0].pc + 16'd2)));
        end
        chk("busy", 32'(bus.busy), 32'((m_out > 0) || (m_q.size() > 0)));

        dfire = bus.imem_req_valid && k_rdy;
        daddr = bus.imem_req_addr;
        if (dfire) begin
            if (n_req == 0) first_addr = daddr;
            n_req++;
        end
        if (bus.instr_valid && k_ir && !k_redir) begin
            if (n_pops == 0) first_pop_pc = bus.instr_pc;
            if (bus.instr_pc == 16'hFFFE) wrap_next = bus.instr_next_pc;
            n_pops++;
        end

        if (k_redir) begin
            m_q.delete();
            m_side.delete();
            if (rsp && m_out > 0) m_out--;
            m_drop = m_out;
            m_pc = k_rpc;
        end else begin
            if (m_q.size() > 0 && k_ir) void'(m_q.pop_front());
            if (rsp && m_out > 0) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else if (m_side.size() > 0) begin
                    e.pc  = m_side.pop_front();
                    e.ins = e.pc ^ 16'hA000;
                    m_q.push_back(e);
                end
            end
            if (rv && k_rdy) begin
                m_side.push_back(m_pc);
                m_pc = m_pc + 16'd2;
                m_out++;
            end
        end
        case (m_state)
            0: m_state = 1;
            1: if (k_halt) m_state = 2;
            default: if (!k_halt) m_state = 1;
        endcase

        if (rsp) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (dfire) begin
            mem_addr.push_back(daddr);
            mem_due.push_back(cyc + int'($urandom_range(k_lat_max, k_lat_min)));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 16'h0000; bus.instr_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'(0));
        chk("rst_req_addr", 32'(bus.imem_req_addr), 32'(0));
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'(0));
        chk("rst_instr", 32'(bus.instr), 32'(0));
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'(0));
        chk("rst_instr_next_pc", 32'(bus.instr_next_pc), 32'(2));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        m_state = 0; m_out = 0; m_drop = 0; m_pc = 16'h0000;
        m_q.delete(); m_side.delete();
        mem_addr.delete(); mem_due.delete();
        k_halt = 0; k_redir = 0; k_rpc = 16'h0000; k_rdy = 1; k_ir = 1;
        k_lat_min = 1; k_lat_max = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);

        // single-cycle memory streaming
        do_reset();
        n_pops = 0; first_pop_pc = 16'hDEAD;
        for (int i = 0; i < 20; i++) step();
        chk("stream_first_pc", 32'(first_pop_pc), 32'(16'h0000));

        // decode stalled: credit limits to DEPTH requests
        do_reset();
        k_ir = 0; n_req = 0;
        for (int i = 0; i < 12; i++) step();
        chk("stall_req_count", 32'(n_req), 32'(DEPTH));
        k_ir = 1; n_req = 0; first_addr = 16'hDEAD;
        for (int i = 0; i < 8; i++) step();
        chk("resume_addr", 32'(first_addr), 32'(16'h0008));

        // latency 3, redirect with requests in flight
        do_reset();
        k_lat_min = 3; k_lat_max = 3;
        for (int i = 0; i < 20 && m_out < 3; i++) step();
        k_redir = 1; k_rpc = 16'h0100;
        step();
        k_redir = 0; n_pops = 0; first_pop_pc = 16'hDEAD;
        for (int i = 0; i < 30 && n_pops == 0; i++) step();
        chk("redirect_first_pc", 32'(first_pop_pc), 32'(16'h0100));

        // redirect colliding with a response and a pop
        k_lat_min = 1; k_lat_max = 1;
        for (int i = 0; i < 20 && !(rsp_due() && m_q.size() > 0); i++) step();
        k_redir = 1; k_rpc = 16'h0200;
        step();
        chk("flush_instr_valid", 32'(bus.instr_valid), 32'(0));
        chk("flush_req_addr", 32'(bus.imem_req_addr), 32'(16'h0200));
        k_redir = 0;
        for (int i = 0; i < 8; i++) step();

        // PC wrap
        k_redir = 1; k_rpc = 16'hFFFC;
        step();
        k_redir = 0; wrap_next = 16'hDEAD;
        for (int i = 0; i < 12; i++) step();
        chk("wrap_next_pc", 32'(wrap_next), 32'(16'h0000));

        // randomized traffic
        k_lat_min = 1; k_lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9, 0) == 0) k_halt = !k_halt;
            k_redir = ($urandom_range(29, 0) == 0);
            k_rpc   = 16'($urandom) & 16'hFFFE;
            k_rdy   = ($urandom_range(3, 0) != 0);
            k_ir    = ($urandom_range(9, 0) < 7);
            step();
        end

        // halt and drain
        k_redir = 0; k_halt = 1; k_rdy = 1; k_ir = 1;
        for (int i = 0; i < 40 && (bus.busy || i < 2); i++) step();
        chk("drain_busy", 32'(bus.busy), 32'(0));
        for (int i = 0; i < 4; i++) step();

        // resume, then asynchronous reset mid-stream
        k_halt = 0;
        for (int i = 0; i < 7; i++) step();
        do_reset();
        for (int i = 0; i < 10; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
